// File: rtl/wf_serial_io_pkg.sv
// Shared types and helpers for the serial I/O scanner: FSM state encoding
// and the frame width calculation used by the top and its sub-module.
package wf_serial_io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Total bits per frame: header, column one-hot, padding, row data.
  function automatic int frame_width(input int num_out, input int num_cols,
                                     input int pad_bits, input int num_rows);
    return num_out + num_cols + pad_bits + num_rows;
  endfunction

endpackage

// File: rtl/wf_frame_debounce.sv
// Frame-level debouncer: a received vector must repeat DEBOUNCE frames in a
// row before it is promoted to the stable output; a promotion pulses change.
module wf_frame_debounce
  import wf_serial_io_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] stable,
  output logic             change
);

  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [3:0]       cnt_reg;
  logic [3:0]       cnt_next;
  logic             change_reg;

  // Repeat counter: saturating count of identical frames, restart at 1.
  always_comb begin
    cnt_next = 4'd1;
    if (sample == prev_reg) begin
      if (cnt_reg >= 4'(DEBOUNCE)) cnt_next = 4'(DEBOUNCE);
      else                         cnt_next = cnt_reg + 4'd1;
    end
  end

  // Evaluate on each new frame; promote once the repeat count is met.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg   <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
      change_reg <= 1'b0;
    end else begin
      change_reg <= 1'b0;
      if (sample_valid) begin
        prev_reg <= sample;
        cnt_reg  <= cnt_next;
        if (cnt_next == 4'(DEBOUNCE) && sample != stable_reg) begin
          stable_reg <= sample;
          change_reg <= 1'b1;
        end
      end
    end
  end

  assign stable = stable_reg;
  assign change = change_reg;

endmodule

// File: rtl/wf_serial_io_scanner.sv
// Serial LED-matrix / input scanner. Each frame shifts out header bits, a
// one-hot column select, padding and inverted row data while shifting the
// board's input chain back in; LOAD frames the transfer (active low).
module wf_serial_io_scanner
  import wf_serial_io_pkg::*;
#(
  parameter int NUM_COLS    = 6,
  parameter int NUM_ROWS    = 8,
  parameter int NUM_OUT     = 8,
  parameter int PAD_BITS    = 2,
  parameter int HALF_PERIOD = 1,
  parameter int DEBOUNCE    = 3,
  localparam int FW = frame_width(NUM_OUT, NUM_COLS, PAD_BITS, NUM_ROWS),
  parameter logic [FW-1:0] IN_INVERT = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scan_en,
  input  logic [NUM_COLS*NUM_ROWS-1:0] led_state,
  input  logic [NUM_OUT-1:0]           header_outputs,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [FW-1:0]                in_raw,
  output logic [FW-1:0]                in_stable,
  output logic                         in_change,
  output logic                         CLK_OUT,
  output logic                         MST_OUT_SLV_IN,
  input  logic                         MST_IN_SLV_OUT,
  output logic                         LOAD
);

  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int BW = $clog2(FW);

  state_t          state_reg;
  logic [7:0]      phase_reg;
  logic [BW-1:0]   bit_cnt_reg;
  logic [CW-1:0]   col_idx_reg;
  logic [FW-1:0]   tx_sr_reg;
  logic [FW-1:0]   rx_sr_reg;
  logic [FW-1:0]   in_raw_reg;
  logic            busy_reg;
  logic            load_reg;
  logic            clk_out_reg;
  logic            frame_done_reg;
  logic            overrun_reg;

  logic [NUM_COLS-1:0] col_onehot;
  logic [NUM_ROWS-1:0] col_leds;
  logic [FW-1:0]       tx_frame;
  logic                phase_last;

  // Column select decode, one output per column.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_sel
    assign col_onehot[gi] = (col_idx_reg == CW'(gi));
  end

  // Row data for the active column.
  always_comb begin
    col_leds = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_idx_reg == CW'(c)) col_leds = led_state[c*NUM_ROWS +: NUM_ROWS];
    end
  end

  // Rows are driven active low on the board, hence the inversion.
  assign tx_frame   = {header_outputs, col_onehot, {PAD_BITS{1'b0}}, ~col_leds};
  assign phase_last = (phase_reg == 8'(HALF_PERIOD - 1));

  // Frame sequencer: serial clock, shift registers, strobe and column rotation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      bit_cnt_reg    <= '0;
      col_idx_reg    <= '0;
      tx_sr_reg      <= '0;
      rx_sr_reg      <= '0;
      in_raw_reg     <= '0;
      busy_reg       <= 1'b0;
      load_reg       <= 1'b1;
      clk_out_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      overrun_reg    <= scan_en && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (scan_en) begin
            state_reg   <= SHIFT_LO;
            busy_reg    <= 1'b1;
            load_reg    <= 1'b0;
            clk_out_reg <= 1'b0;
            tx_sr_reg   <= tx_frame;
            bit_cnt_reg <= '0;
            phase_reg   <= '0;
          end
        end
        SHIFT_LO: begin
          if (phase_last) begin
            phase_reg   <= '0;
            state_reg   <= SHIFT_HI;
            clk_out_reg <= 1'b1;
            rx_sr_reg   <= {rx_sr_reg[FW-2:0], MST_IN_SLV_OUT};
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (phase_last) begin
            phase_reg <= '0;
            tx_sr_reg <= {tx_sr_reg[FW-2:0], 1'b0};
            if (bit_cnt_reg < BW'(FW - 1)) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              clk_out_reg <= 1'b0;
              state_reg   <= SHIFT_LO;
            end else begin
              // Clock is held high through the latch strobe.
              load_reg  <= 1'b1;
              state_reg <= LATCH;
            end
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        LATCH: begin
          if (phase_last) begin
            phase_reg      <= '0;
            bit_cnt_reg    <= '0;
            state_reg      <= IDLE;
            clk_out_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
            in_raw_reg     <= rx_sr_reg ^ IN_INVERT;
            // Advance here so a back-to-back frame already sees the next column.
            if (col_idx_reg == CW'(NUM_COLS - 1)) col_idx_reg <= '0;
            else                                  col_idx_reg <= col_idx_reg + 1'b1;
          end else begin
            phase_reg <= phase_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  wf_frame_debounce #(
    .WIDTH    (FW),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (frame_done_reg),
    .sample       (in_raw_reg),
    .stable       (in_stable),
    .change       (in_change)
  );

  assign busy           = busy_reg;
  assign frame_done     = frame_done_reg;
  assign overrun        = overrun_reg;
  assign in_raw         = in_raw_reg;
  assign CLK_OUT        = clk_out_reg;
  assign MST_OUT_SLV_IN = tx_sr_reg[FW-1];
  assign LOAD           = load_reg;

endmodule

// File: doc/wf_serial_io_scanner.md
WF_SERIAL_IO_SCANNER -- requirements
Module: wf_serial_io_scanner

Interface
REQ-001 Parameter NUM_COLS, default 6: LED matrix columns, driven one-hot, one column per frame.
REQ-002 Parameter NUM_ROWS, default 8: LED matrix rows per column.
REQ-003 Parameter NUM_OUT, default 8: header output bits, sent first in each frame.
REQ-004 Parameter PAD_BITS, default 2: zero bits sent between the column field and the row field.
REQ-005 Parameter HALF_PERIOD, default 1 (range 1..255): CLK_OUT half-period, in clk cycles.
REQ-006 Parameter DEBOUNCE, default 3 (range 1..15): consecutive identical frames required before the stable input vector updates.
REQ-007 Parameter IN_INVERT, default all-zero, width FW: XOR mask applied to received bits; FW = NUM_OUT+NUM_COLS+PAD_BITS+NUM_ROWS.
REQ-008 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-009 Port reset, input, 1: synchronous, active-high reset.
REQ-010 Port scan_en, input, 1: one-cycle frame start request.
REQ-011 Port led_state, input, NUM_COLS*NUM_ROWS: active-high LED on; column c occupies bits [c*NUM_ROWS +: NUM_ROWS].
REQ-012 Port header_outputs, input, NUM_OUT: header output values.
REQ-013 Port busy, output, 1: high while a frame is in progress.
REQ-014 Port frame_done, output, 1: one-cycle pulse at the end of each frame.
REQ-015 Port overrun, output, 1: one-cycle pulse when scan_en arrives while busy.
REQ-016 Port in_raw, output, FW: received frame after the IN_INVERT mask is applied.
REQ-017 Port in_stable, output, FW: debounced copy of in_raw.
REQ-018 Port in_change, output, 1: one-cycle pulse whenever in_stable changes value.
REQ-019 Port CLK_OUT, output, 1: serial clock to the board.
REQ-020 Port MST_OUT_SLV_IN, output, 1: serial data out, MSB first.
REQ-021 Port MST_IN_SLV_OUT, input, 1: serial data in.
REQ-022 Port LOAD, output, 1: active-low frame strobe; high when idle.

Function
REQ-023 FSM states SHALL be exactly IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-024 IDLE + scan_en: next cycle the block SHALL be in SHIFT_LO with busy=1 and LOAD=0, and the shift register SHALL hold the transmit frame.
  - Transmit frame = {header_outputs, one-hot(col_idx), PAD_BITS zeros, ~led_state column col_idx}.
  - Data is captured in the same cycle scan_en is accepted.
REQ-025 SHIFT_LO SHALL last HALF_PERIOD cycles with CLK_OUT=0 and MST_OUT_SLV_IN = shift register MSB.
REQ-026 On SHIFT_LO -> SHIFT_HI, CLK_OUT SHALL rise and MST_IN_SLV_OUT SHALL be sampled into the receive register LSB.
  - The receive register shifts left by one on each sample.
REQ-027 SHIFT_HI SHALL last HALF_PERIOD cycles.
  - On exit, CLK_OUT falls and the transmit register shifts left, filling with 0.
  - Bit counter < FW-1: go to SHIFT_LO and increment the counter.
  - Otherwise: go to LATCH.
REQ-028 LATCH SHALL last HALF_PERIOD cycles with LOAD=1 and CLK_OUT=1, then return to IDLE with CLK_OUT=0.
REQ-029 busy SHALL be high for exactly 2*HALF_PERIOD*FW + HALF_PERIOD cycles per frame.
  - Defaults (FW=24, HALF_PERIOD=1): 49 cycles.
REQ-030 frame_done SHALL pulse on the first IDLE cycle after a frame.
  - In that same cycle, in_raw SHALL update to receive register XOR IN_INVERT.
REQ-031 col_idx SHALL advance by 1 on each frame_done, wrapping from NUM_COLS-1 to 0.
REQ-032 scan_en while busy SHALL be ignored: no restart, no queueing, overrun pulses for one cycle.
REQ-033 scan_en in the same cycle as frame_done SHALL be accepted; this is a back-to-back frame and does not pulse overrun.
REQ-034 Debounce is evaluated at each frame_done, on the new in_raw against the previous in_raw.
  - Equal: the 4-bit counter saturates at DEBOUNCE.
  - Different: the counter clears to 1.
  - When the counter reaches DEBOUNCE and in_raw != in_stable: in_stable <= in_raw, and in_change pulses one cycle later.
REQ-035 led_state and header_outputs changes during a frame SHALL NOT affect that frame.

Reset
REQ-036 Reset SHALL force, on the next cycle, regardless of state (including mid-frame):
  - FSM = IDLE, busy=0, LOAD=1, CLK_OUT=0, MST_OUT_SLV_IN=0.
  - frame_done=0, overrun=0, in_change=0.
  - in_raw=0, in_stable=0, debounce counter=0, col_idx=0, bit counter=0.
REQ-037 scan_en asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-038 Shared package wf_serial_io_pkg SHALL hold:
  - the state enum;
  - a frame_width function of (NUM_OUT, NUM_COLS, PAD_BITS, NUM_ROWS).
REQ-039 Debounce and change detection SHALL be a sub-module, wf_frame_debounce, parametrised by width and DEBOUNCE.
REQ-040 Serial timing, shift registers and column rotation SHALL stay in the top module.

Verification
REQ-041 Reset mid-frame (cycle 10 after scan_en) -> next cycle LOAD=1, CLK_OUT=0, busy=0, col_idx=0.
REQ-042 Defaults, header_outputs=8'h3C, led_state column 0 = 8'hA5, scan_en -> MOSI stream 24'h3C045A, busy=49 cycles, col_idx=1 after frame_done.
REQ-043 MISO model returns 24'h123456, IN_INVERT=24'h00FFFF -> in_raw=24'h12CBA9 at frame_done.
REQ-044 DEBOUNCE=3, in_raw sequence A,A,B,B,B -> in_stable becomes B at the 5th frame_done, in_change pulses once; no update on the A,A pair.
REQ-045 scan_en at cycle 5 of a frame -> overrun pulses once, frame length unchanged; scan_en coincident with frame_done -> new frame starts, no overrun.
REQ-046 HALF_PERIOD=4, NUM_COLS=3 -> CLK_OUT high/low are 4 cycles each; col_idx sequence 0,1,2,0 over 4 frames.
